// File: rtl/jtkunio_video_pkg.sv
// jtkunio_video_pkg: shared kunio video timing defaults and wrap-aware window helpers
package jtkunio_video_pkg;
  localparam int OW = 4;
  localparam int DEF_HW = 9;
  localparam int DEF_VW = 9;
  localparam int DEF_HCNT_START = 0;
  localparam int DEF_HCNT_END = 383;
  localparam int DEF_HB_START = 260;
  localparam int DEF_HB_END = 16;
  localparam int DEF_HS_START = 319;
  localparam int DEF_HS_END = 351;
  localparam int DEF_VCNT_START = 0;
  localparam int DEF_VCNT_END = 271;
  localparam int DEF_VB_START = 240;
  localparam int DEF_VB_END = 8;
  localparam int DEF_VS_START = 258;
  localparam int DEF_VS_END = 261;
  localparam int DEF_FCW = 8;
  function automatic int wrap_add(input int v, input int off, input int lo, input int hi);
    int r = v + off;
    int n = hi - lo + 1;
    return r > hi ? r - n : r < lo ? r + n : r;
  endfunction
  function automatic logic in_win(input int x, input int lo, input int hi);
    return lo <= hi ? (x >= lo && x < hi) : (x >= lo || x < hi);
  endfunction
endpackage

// File: rtl/jtkunio_vtiming_win.sv
// jtkunio_vtiming_win: one timing axis with lookahead counters, blank window and offset sync window
module jtkunio_vtiming_win
  import jtkunio_video_pkg::*;
#(
  parameter int CW = 9,
  parameter int CNT_START = 0,
  parameter int CNT_END = 383,
  parameter int B_START = 260,
  parameter int B_END = 16,
  parameter int S_START = 319,
  parameter int S_END = 351
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen_i,
  input  logic                 sync_en_i,
  input  logic signed [OW-1:0] off_i,
  output logic [CW-1:0]        cnt_o,
  output logic [CW-1:0]        nxt_o,
  output logic [CW-1:0]        nxt2_o,
  output logic                 wrap_o,
  output logic                 lbl_o,
  output logic                 sync_o,
  output logic                 sedge_o
);
  localparam bit BAD = CNT_END <= CNT_START || CNT_START < 0 || CNT_END >= 2**CW ||
                       B_START < CNT_START || B_START > CNT_END || B_END < CNT_START || B_END > CNT_END ||
                       S_START < CNT_START || S_START > CNT_END || S_END < CNT_START || S_END > CNT_END;
  if (BAD) begin : g_bad
    $error("jtkunio_vtiming_win: timing parameter outside counter range");
  end
  localparam logic [CW-1:0] ST = CW'(CNT_START);
  localparam logic [CW-1:0] EN = CW'(CNT_END);
  localparam logic [CW-1:0] R1 = CW'(wrap_add(CNT_START, 1, CNT_START, CNT_END));
  localparam logic [CW-1:0] R2 = CW'(wrap_add(CNT_START, 2, CNT_START, CNT_END));
  logic [CW-1:0] cnt_q, nxt_q, nxt2_q, cnt_d, nxt_d, nxt2_d, s_lo, s_hi;
  logic lbl_q, sync_q, lbl_d, sync_d;
  always_comb begin
    cnt_d = cen_i ? nxt_q : cnt_q;
    nxt_d = cen_i ? nxt2_q : nxt_q;
    nxt2_d = !cen_i ? nxt2_q : nxt2_q == EN ? ST : nxt2_q + CW'(1);
    s_lo = CW'(wrap_add(S_START, int'(off_i), CNT_START, CNT_END));
    s_hi = CW'(wrap_add(S_END, int'(off_i), CNT_START, CNT_END));
    lbl_d = cen_i ? !in_win(int'(cnt_d), B_START, B_END) : lbl_q;
    sync_d = sync_en_i ? in_win(int'(cnt_d), int'(s_lo), int'(s_hi)) : sync_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ST;
      nxt_q <= R1;
      nxt2_q <= R2;
      lbl_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nxt_q <= nxt_d;
      nxt2_q <= nxt2_d;
      lbl_q <= lbl_d;
      sync_q <= sync_d;
    end
  end
  assign cnt_o = cnt_q;
  assign nxt_o = nxt_q;
  assign nxt2_o = nxt2_q;
  assign wrap_o = cnt_q == EN;
  assign lbl_o = lbl_q;
  assign sync_o = sync_q;
  assign sedge_o = cen_i && cnt_d == s_lo;
endmodule

// File: rtl/jtkunio_vtiming.sv
// jtkunio_vtiming: kunio video timing with sync centring, two-line lookahead, flip counters and frame count
module jtkunio_vtiming
  import jtkunio_video_pkg::*;
#(
  parameter int HW = DEF_HW,
  parameter int VW = DEF_VW,
  parameter int HCNT_START = DEF_HCNT_START,
  parameter int HCNT_END = DEF_HCNT_END,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END = DEF_HS_END,
  parameter int VCNT_START = DEF_VCNT_START,
  parameter int VCNT_END = DEF_VCNT_END,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END = DEF_VS_END,
  parameter int FCW = DEF_FCW
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           pxl_cen,
  input  logic           flip,
  input  logic [OW-1:0]  hoffset,
  input  logic [OW-1:0]  voffset,
  output logic [HW-1:0]  hdump,
  output logic [VW-1:0]  vdump,
  output logic [VW-1:0]  vrender,
  output logic [VW-1:0]  vrender1,
  output logic [HW-1:0]  hf,
  output logic [VW-1:0]  vf,
  output logic           Hinit,
  output logic           Vinit,
  output logic           LHBL,
  output logic           LVBL,
  output logic           HS,
  output logic           VS,
  output logic           h8,
  output logic           v8,
  output logic [FCW-1:0] frame_cnt
);
  logic signed [OW-1:0] hoff_q, voff_q;
  logic [FCW-1:0] frame_q;
  logic [HW-1:0] h_nxt, h_nxt2;
  logic v_wrap, hs_rise, vs_edge, unused_la;
  jtkunio_vtiming_win #(
    .CW(HW), .CNT_START(HCNT_START), .CNT_END(HCNT_END),
    .B_START(HB_START), .B_END(HB_END), .S_START(HS_START), .S_END(HS_END)
  ) u_h (
    .clk(clk), .rst(rst), .cen_i(pxl_cen), .sync_en_i(pxl_cen), .off_i(hoff_q),
    .cnt_o(hdump), .nxt_o(h_nxt), .nxt2_o(h_nxt2), .wrap_o(Hinit),
    .lbl_o(LHBL), .sync_o(HS), .sedge_o(hs_rise)
  );
  // VS is re-evaluated only at the HS rise so both syncs stay phase-aligned
  jtkunio_vtiming_win #(
    .CW(VW), .CNT_START(VCNT_START), .CNT_END(VCNT_END),
    .B_START(VB_START), .B_END(VB_END), .S_START(VS_START), .S_END(VS_END)
  ) u_v (
    .clk(clk), .rst(rst), .cen_i(pxl_cen & Hinit), .sync_en_i(hs_rise), .off_i(voff_q),
    .cnt_o(vdump), .nxt_o(vrender), .nxt2_o(vrender1), .wrap_o(v_wrap),
    .lbl_o(LVBL), .sync_o(VS), .sedge_o(vs_edge)
  );
  assign unused_la = ^{h_nxt, h_nxt2, vs_edge};
  assign Vinit = Hinit & v_wrap;
  assign hf = hdump ^ {HW{flip}};
  assign vf = vdump ^ {VW{flip}};
  assign h8 = hdump[3];
  assign v8 = vdump[3] & (LVBL | vdump[2]);
  assign frame_cnt = frame_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hoff_q <= '0;
      voff_q <= '0;
      frame_q <= '0;
    end else if (pxl_cen && Vinit) begin
      hoff_q <= $signed(hoffset);
      voff_q <= $signed(voffset);
      frame_q <= frame_q + FCW'(1);
    end
  end
endmodule

// File: tb/tb_jtkunio_vtiming.sv
// tb_jtkunio_vtiming: reduced-geometry timing bench with arithmetic reference model and pinned literals
module tb_jtkunio_vtiming;
  localparam int HN = 64, VN = 40, F = HN * VN, FM = 8;
  localparam int HBS = 40, HBE = 8, HSS = 48, HSE = 56;
  localparam int VBS = 24, VBE = 4, VSS = 38, VSE = 2;
  logic clk = 0, rst = 1, pxl_cen = 0, flip = 0;
  logic [3:0] hoffset = 0, voffset = 0;
  logic [8:0] hdump, vdump, vrender, vrender1, hf, vf;
  logic Hinit, Vinit, LHBL, LVBL, HS, VS, h8, v8;
  logic [2:0] frame_cnt;
  int checks = 0, failures = 0, prints = 0, pos = 0;
  int n = 0, hoff_m = 0, voff_m = 0, voffp_m = 0;
  bit valid = 0;
  jtkunio_vtiming #(
    .HW(9), .VW(9), .HCNT_START(0), .HCNT_END(HN - 1), .HB_START(HBS), .HB_END(HBE),
    .HS_START(HSS), .HS_END(HSE), .VCNT_START(0), .VCNT_END(VN - 1), .VB_START(VBS),
    .VB_END(VBE), .VS_START(VSS), .VS_END(VSE), .FCW(3)
  ) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip), .hoffset(hoffset), .voffset(voffset),
    .hdump(hdump), .vdump(vdump), .vrender(vrender), .vrender1(vrender1), .hf(hf), .vf(vf),
    .Hinit(Hinit), .Vinit(Vinit), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .h8(h8), .v8(v8),
    .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  function automatic bit inw(input int x, input int lo, input int hi);
    return lo <= hi ? (x >= lo && x < hi) : (x >= lo || x < hi);
  endfunction
  function automatic int wr(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      n <= 0; hoff_m <= 0; voff_m <= 0; voffp_m <= 0; valid <= 1;
    end else if (pxl_cen) begin
      n <= n + 1;
      if ((n + 1) % F == 0) begin
        voffp_m <= voff_m;
        hoff_m <= int'($signed(hoffset));
        voff_m <= int'($signed(voffset));
      end
    end
  end
  always @(negedge clk) begin
    int hd, ln, vd, r, vo, fm;
    bit lhbl, lvbl, hs, vs;
    logic [64:0] e, g;
    if (valid) begin
      hd = n % HN; ln = n / HN; vd = ln % VN; fm = flip ? 511 : 0;
      lhbl = !inw(hd, HBS, HBE);
      lvbl = !inw(vd, VBS, VBE);
      hs = inw(hd, wr(HSS + hoff_m, HN), wr(HSE + hoff_m, HN));
      r = hd >= wr(HSS + hoff_m, HN) ? ln : ln - 1;
      vo = (r / VN == n / F) ? voff_m : voffp_m;
      vs = r >= 0 && inw(r % VN, wr(VSS + vo, VN), wr(VSE + vo, VN));
      e = {9'(hd), 9'(vd), 9'((vd + 1) % VN), 9'((vd + 2) % VN), 9'(hd ^ fm), 9'(vd ^ fm),
           1'(hd == HN - 1), 1'(hd == HN - 1 && vd == VN - 1), lhbl, lvbl, hs, vs,
           1'((hd >> 3) & 1), 1'(((vd >> 3) & 1) & (lvbl | ((vd >> 2) & 1))), 3'((n / F) % FM)};
      g = {hdump, vdump, vrender, vrender1, hf, vf, Hinit, Vinit, LHBL, LVBL, HS, VS, h8, v8, frame_cnt};
      checks++;
      if (g !== e) begin
        failures++;
        if (prints < 20) begin
          prints++;
          $display("FAIL model_cycle n=%0d got=%h exp=%h", n, g, e);
        end
      end
    end
  end
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic tick(input logic c);
    pxl_cen = c;
    @(posedge clk);
    #1;
    if (rst) pos = 0;
    else if (c) pos++;
  endtask
  task automatic go(input int t);
    while (pos < t) tick(1'b1);
  endtask
  initial begin
    tick(1'b1);
    lit("rst_hdump", 32'(hdump), 0); lit("rst_vdump", 32'(vdump), 0);
    lit("rst_vrender", 32'(vrender), 1); lit("rst_vrender1", 32'(vrender1), 2);
    lit("rst_lhbl", 32'(LHBL), 0); lit("rst_frame", 32'(frame_cnt), 0);
    rst = 0;
    go(7);  lit("lhbl_h7", 32'(LHBL), 0);
    go(8);  lit("lhbl_h8", 32'(LHBL), 1);
    go(39); lit("lhbl_h39", 32'(LHBL), 1);
    go(40); lit("lhbl_h40", 32'(LHBL), 0);
    go(62); lit("hinit_h62", 32'(Hinit), 0);
    go(63); lit("hinit_h63", 32'(Hinit), 1); lit("vinit_h63", 32'(Vinit), 0);
    repeat (100) tick(1'($urandom_range(0, 1)));
    go(10 * HN + 5);
    #2 flip = 1;
    #1 lit("flip_hf", 32'(hf), 506); lit("flip_vf", 32'(vf), 501);
    flip = 0;
    #1 lit("noflip_hf", 32'(hf), 5);
    go(20 * HN);
    hoffset = 4'hC; voffset = 4'd2;
    go(21 * HN + 47); lit("hs_f0_47", 32'(HS), 0);
    go(21 * HN + 48); lit("hs_f0_48", 32'(HS), 1);
    go(21 * HN + 55); lit("hs_f0_55", 32'(HS), 1);
    go(21 * HN + 56); lit("hs_f0_56", 32'(HS), 0);
    go(24 * HN - 1);  lit("lvbl_v23", 32'(LVBL), 1);
    go(24 * HN);      lit("lvbl_v24", 32'(LVBL), 0); lit("v8_v24", 32'(v8), 0);
    go(28 * HN + 10); lit("v8_v28", 32'(v8), 1);
    go(F - 1); lit("vinit_end", 32'(Vinit), 1); lit("frame_f0", 32'(frame_cnt), 0);
    go(F); lit("frame_f1", 32'(frame_cnt), 1); lit("wrap_vdump", 32'(vdump), 0);
    go(F + 43); lit("hs_f1_43", 32'(HS), 0);
    go(F + 44); lit("hs_f1_44", 32'(HS), 1);
    go(F + 51); lit("hs_f1_51", 32'(HS), 1);
    go(F + 52); lit("hs_f1_52", 32'(HS), 0);
    go(F + 3 * HN + 44); lit("vs_f1_v3", 32'(VS), 1);
    go(F + 4 * HN + 43); lit("vs_f1_v4_pre", 32'(VS), 1);
    go(F + 4 * HN + 44); lit("vs_f1_v4_rise", 32'(VS), 0);
    go(F + 10 * HN);
    hoffset = 0; voffset = 0;
    go(F + 38 * HN); lit("vr_v38", 32'(vrender), 39); lit("vr1_v38", 32'(vrender1), 0);
    go(F + 39 * HN); lit("vr_v39", 32'(vrender), 0);  lit("vr1_v39", 32'(vrender1), 1);
    go(8 * F - 1); lit("frame_7", 32'(frame_cnt), 7);
    go(8 * F);     lit("frame_wrap", 32'(frame_cnt), 0);
    go(8 * F + 15 * HN + 50); lit("pre_rst_hs", 32'(HS), 1); lit("pre_rst_lvbl", 32'(LVBL), 1);
    rst = 1;
    tick(1'b0);
    lit("mrst_hdump", 32'(hdump), 0); lit("mrst_vdump", 32'(vdump), 0);
    lit("mrst_vrender", 32'(vrender), 1); lit("mrst_vrender1", 32'(vrender1), 2);
    lit("mrst_flags", 32'({LHBL, LVBL, HS, VS}), 0); lit("mrst_frame", 32'(frame_cnt), 0);
    rst = 0;
    repeat (200) tick(1'($urandom_range(0, 1)));
    @(negedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
